// File: rtl/serial_alu_ctrl_if.sv
// Bus bundle for the bit-serial ALU sequencer: request side (start/op/a/b)
// and registered response side (busy/done/result/flags), plus FSM state
// visibility for debug.
//
// Handshake: start is a request that is sampled only while the sequencer
// is idle (busy=0, done=0). A start seen in any other state is dropped,
// not queued. done is a one-cycle pulse; result, carry_out and zero are
// valid from that pulse onward and are held until the next completion.
interface serial_alu_ctrl_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;
  logic       zero;
  logic [1:0] state;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, zero, state
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, zero, state
  );
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for the 8-bit ALU. One 1-bit adder/subtractor/logic
// slice is reused across the eight operand bits, LSB first, one bit per
// clock. Result bits shift into a register MSB-in so bit 0 lands at [0].
module serial_alu_ctrl (
  input  logic             clk,
  input  logic             rst,
  serial_alu_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

  logic [1:0] state, state_nx;
  logic [2:0] cnt;
  logic [2:0] op_r;
  logic [7:0] a_r, b_r, sr;
  logic       c_r;
  logic [7:0] result_r;
  logic       carry_r, zero_r;

  logic       ak, bk, x, bit_k, c_nx, arith;
  logic [7:0] final_val;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_RUN;
      S_RUN:   if (cnt == 3'd7) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.busy  = (state == S_RUN);
    bus.done  = (state == S_DONE);
    bus.state = state;
  end

  // One-bit slice: sum/difference and carry/borrow for the current bit.
  always_comb begin
    ak    = a_r[cnt];
    bk    = b_r[cnt];
    x     = ak ^ bk;
    bit_k = 1'b0;
    c_nx  = 1'b0;
    arith = 1'b0;
    case (op_r)
      OP_ADD, OP_INC: begin
        arith = 1'b1;
        bit_k = x ^ c_r;
        c_nx  = (ak & bk) | (c_r & x);
      end
      OP_SUB, OP_DEC: begin
        arith = 1'b1;
        bit_k = x ^ c_r;
        c_nx  = (~ak & bk) | (c_r & ~x);
      end
      OP_AND:  bit_k = ak & bk;
      OP_OR:   bit_k = ak | bk;
      OP_XOR:  bit_k = x;
      OP_NOT:  bit_k = ~ak;
      default: bit_k = 1'b0;
    endcase
    final_val = {bit_k, sr[7:1]};
  end

  // Datapath: capture in IDLE, one shift per RUN cycle, publish on last bit.
  // INC/DEC reuse the adder with b forced to zero and carry-in of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 3'd0;
      op_r     <= 3'd0;
      a_r      <= 8'h00;
      b_r      <= 8'h00;
      c_r      <= 1'b0;
      sr       <= 8'h00;
      result_r <= 8'h00;
      carry_r  <= 1'b0;
      zero_r   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_r <= bus.op;
            a_r  <= bus.a;
            b_r  <= (bus.op[2] & bus.op[1]) ? 8'h00 : bus.b;
            c_r  <= bus.op[2] & bus.op[1];
            cnt  <= 3'd0;
          end
        end
        S_RUN: begin
          sr  <= final_val;
          c_r <= c_nx;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            result_r <= final_val;
            carry_r  <= arith ? c_nx : 1'b0;
            zero_r   <= (final_val == 8'h00);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = result_r;
  assign bus.carry_out = carry_r;
  assign bus.zero      = zero_r;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl: drivers push expected responses into
// a queue, an independent monitor pops and compares on every done pulse.
module tb_serial_alu_ctrl;

  logic clk;
  logic rst;
  serial_alu_ctrl_if bus ();

  serial_alu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // {result, carry_out, zero}
  logic [9:0] exp_q[$];

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("result", {24'd0, bus.result}, {24'd0, e[9:2]});
        check("carry_out", {31'd0, bus.carry_out}, {31'd0, e[1]});
        check("zero", {31'd0, bus.zero}, {31'd0, e[0]});
      end
    end
  end

  // Driver: one operation, checking busy/done timing cycle by cycle.
  // inj pulses a second start in RUN and in DONE and scrambles a/b/op mid-RUN.
  task automatic run_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] er, input logic ec, input bit inj);
    exp_q.push_back({er, ec, (er == 8'h00)});
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      check("busy_run", {31'd0, bus.busy}, 32'd1);
      check("done_run", {31'd0, bus.done}, 32'd0);
      if (inj && i == 3) begin
        bus.start = 1'b1; bus.op = ~o; bus.a = ~av; bus.b = ~bv;
      end
      if (inj && i == 4) bus.start = 1'b0;
      if (inj && i == 5) begin
        bus.a = 8'($urandom_range(0, 255));
        bus.b = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    check("done_pulse", {31'd0, bus.done}, 32'd1);
    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
    if (inj) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("idle_after", {30'd0, bus.state}, 32'd0);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(name, {31'd0, bus.done}, 32'd0);
    end
  endtask

  initial begin
    int t0, t1;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 8'h00; bus.b = 8'h00;
    repeat (3) @(negedge clk);
    // Reset wins over start in the same cycle.
    bus.start = 1'b1;
    @(negedge clk);
    check("rst_state", {30'd0, bus.state}, 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", {24'd0, bus.result}, 32'h00);
    check("rst_carry", {31'd0, bus.carry_out}, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd1);

    // Arithmetic.
    run_op(3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op(3'b001, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0);
    run_op(3'b001, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0);
    run_op(3'b110, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    run_op(3'b111, 8'h00, 8'hAA, 8'hFF, 1'b1, 1'b0);
    run_op(3'b000, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0);
    run_op(3'b110, 8'h7F, 8'h55, 8'h80, 1'b0, 1'b0);

    // Logic sweep.
    run_op(3'b010, 8'hC3, 8'h5A, 8'h42, 1'b0, 1'b0);
    run_op(3'b011, 8'hC3, 8'h5A, 8'hDB, 1'b0, 1'b0);
    run_op(3'b100, 8'hC3, 8'h5A, 8'h99, 1'b0, 1'b0);
    run_op(3'b101, 8'hC3, 8'h5A, 8'h3C, 1'b0, 1'b0);

    // Ignored starts in RUN/DONE and operand changes mid-RUN.
    run_op(3'b000, 8'h21, 8'h43, 8'h64, 1'b0, 1'b1);
    expect_quiet("no_queued_start", 14);

    // Reset mid-RUN aborts.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 8'h80; bus.b = 8'h81;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_result", {24'd0, bus.result}, 32'h00);
    check("abort_zero", {31'd0, bus.zero}, 32'd1);
    check("abort_carry", {31'd0, bus.carry_out}, 32'd0);
    expect_quiet("abort_no_done", 12);

    run_op(3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

    // start held high: one operation every 10 cycles.
    exp_q.push_back({8'h02, 1'b0, 1'b0});
    exp_q.push_back({8'h02, 1'b0, 1'b0});
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 8'h01; bus.b = 8'h01;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (t0 < 0) t0 = i;
        else begin
          t1 = i;
          break;
        end
      end
    end
    bus.start = 1'b0;
    check("first_latency", t0, 32'd8);
    check("throughput_period", t1 - t0, 32'd10);
    expect_quiet("after_stream", 12);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
